// File: rtl/if_fetch_unit.sv
// Fetch-stage controller: owns the PC, selects the next PC from decode
// redirect requests (delay-slot semantics, no flush), and loads the IF/ID
// pipeline register with the instruction returned by the IM.
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] F_Instr,
    output logic [31:0] F_PC,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_PC8,
    output logic        D_valid,
    output logic        fetch_err
);

    // One bit wider than the PC so the upper bound cannot overflow.
    localparam logic [32:0] IM_LIMIT = 33'(IM_BASE) + 33'(IM_WORDS) * 33'd4;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_J   = 2'd2;
    localparam logic [1:0] SEL_JR  = 2'd3;

    logic [31:0] pc_plus4_c;
    logic [31:0] br_offset_c;
    logic [31:0] br_target_c;
    logic [31:0] j_target_c;
    logic [31:0] npc_c;
    logic        fetch_legal_c;

    // Candidate targets; all sums wrap modulo 2^32.
    always_comb begin
        pc_plus4_c  = F_PC + 32'd4;
        br_offset_c = {{14{D_imm26[15]}}, D_imm26[15:0], 2'b00};
        br_target_c = D_PC + 32'd4 + br_offset_c;
        j_target_c  = {D_PC[31:28], D_imm26, 2'b00};
    end

    // Next-PC selection from the decode request.
    always_comb begin
        npc_c = pc_plus4_c;
        case (npc_sel)
            SEL_SEQ: npc_c = pc_plus4_c;
            SEL_BR:  npc_c = br_taken ? br_target_c : pc_plus4_c;
            SEL_J:   npc_c = j_target_c;
            SEL_JR:  npc_c = D_rs_data;
            default: npc_c = pc_plus4_c;
        endcase
    end

    // A fetch is legal when word-aligned and inside the IM window.
    always_comb begin
        fetch_legal_c = (F_PC[1:0] == 2'b00)
                     && (F_PC >= IM_BASE)
                     && ({1'b0, F_PC} < IM_LIMIT);
    end

    // PC and IF/ID register; the word at F_PC (delay slot) is always captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_PC      <= PC_RESET;
            D_Instr   <= 32'd0;
            D_PC      <= PC_RESET;
            D_PC8     <= PC_RESET + 32'd8;
            D_valid   <= 1'b0;
            fetch_err <= 1'b0;
        end else if (!stall) begin
            F_PC      <= npc_c;
            D_Instr   <= fetch_legal_c ? F_Instr : 32'd0;
            D_PC      <= F_PC;
            D_PC8     <= F_PC + 32'd8;
            D_valid   <= fetch_legal_c;
            fetch_err <= !fetch_legal_c;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small behavioural IM.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_data;
    logic [31:0] F_Instr;
    logic [31:0] F_PC;
    logic [31:0] D_Instr;
    logic [31:0] D_PC;
    logic [31:0] D_PC8;
    logic        D_valid;
    logic        fetch_err;

    int vectors;
    int miscompares;

    if_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .D_imm26   (D_imm26),
        .D_rs_data (D_rs_data),
        .F_Instr   (F_Instr),
        .F_PC      (F_PC),
        .D_Instr   (D_Instr),
        .D_PC      (D_PC),
        .D_PC8     (D_PC8),
        .D_valid   (D_valid),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural IM: three fixed words, otherwise a tag derived from the address.
    always_comb begin
        case (F_PC)
            32'h0000_3000: F_Instr = 32'h1111_1111;
            32'h0000_3004: F_Instr = 32'h2222_2222;
            32'h0000_3008: F_Instr = 32'h3333_3333;
            default:       F_Instr = {16'hC0DE, F_PC[15:0]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] fpc, input logic [31:0] instr,
                         input logic [31:0] dpc, input logic [31:0] dpc8,
                         input logic vld, input logic err);
        chk({tag, ".F_PC"},      F_PC,              fpc);
        chk({tag, ".D_Instr"},   D_Instr,           instr);
        chk({tag, ".D_PC"},      D_PC,              dpc);
        chk({tag, ".D_PC8"},     D_PC8,             dpc8);
        chk({tag, ".D_valid"},   32'(D_valid),      32'(vld));
        chk({tag, ".fetch_err"}, 32'(fetch_err),    32'(err));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        npc_sel   = 2'd0;
        br_taken  = 1'b0;
        D_imm26   = 26'd0;
        D_rs_data = 32'd0;

        // Reset state
        edge1();
        chk_d("reset", 32'h3000, 32'h0, 32'h3000, 32'h3008, 1'b0, 1'b0);
        reset = 1'b0;

        // Sequential fetch, D lags F by one cycle
        edge1();
        chk_d("seq1", 32'h3004, 32'h1111_1111, 32'h3000, 32'h3008, 1'b1, 1'b0);
        edge1();
        chk_d("seq2", 32'h3008, 32'h2222_2222, 32'h3004, 32'h300C, 1'b1, 1'b0);

        // Taken branch from D_PC=0x3004, offset -2 words: target 0x3000; delay slot 0x3008 captured
        npc_sel  = 2'd1;
        br_taken = 1'b1;
        D_imm26  = 26'h000_FFFE;
        edge1();
        chk_d("br_taken", 32'h3000, 32'h3333_3333, 32'h3008, 32'h3010, 1'b1, 1'b0);

        // Not-taken branch: falls through to F_PC+4
        br_taken = 1'b0;
        edge1();
        chk_d("br_nt", 32'h3004, 32'h1111_1111, 32'h3000, 32'h3008, 1'b1, 1'b0);

        npc_sel = 2'd0;
        edge1();
        chk("seq3.F_PC", F_PC, 32'h3008);

        // Stall 3 cycles with a jump pending: everything frozen
        stall   = 1'b1;
        npc_sel = 2'd2;
        D_imm26 = 26'h000_0C40;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk_d("stall", 32'h3008, 32'h2222_2222, 32'h3004, 32'h300C, 1'b1, 1'b0);
        end

        // Release: re-presented jump acts on the first non-stalled edge
        stall = 1'b0;
        edge1();
        chk_d("jump", 32'h3100, 32'h3333_3333, 32'h3008, 32'h3010, 1'b1, 1'b0);

        // jr to 0x3020; delay slot at 0x3100 captured first
        npc_sel   = 2'd3;
        D_rs_data = 32'h3020;
        edge1();
        chk_d("jr", 32'h3020, 32'hC0DE_3100, 32'h3100, 32'h3108, 1'b1, 1'b0);

        // jr to misaligned 0x3002
        D_rs_data = 32'h3002;
        edge1();
        chk_d("jr_mis", 32'h3002, 32'hC0DE_3020, 32'h3020, 32'h3028, 1'b1, 1'b0);

        // Misaligned fetch captured as fault; jr back to 0x3000
        D_rs_data = 32'h3000;
        edge1();
        chk_d("fault", 32'h3000, 32'h0, 32'h3002, 32'h300A, 1'b0, 1'b1);

        // fetch_err holds while stalled
        stall = 1'b1;
        edge1();
        chk_d("fault_hold", 32'h3000, 32'h0, 32'h3002, 32'h300A, 1'b0, 1'b1);

        // Legal capture clears the fault
        stall   = 1'b0;
        npc_sel = 2'd0;
        edge1();
        chk_d("recover", 32'h3004, 32'h1111_1111, 32'h3000, 32'h3008, 1'b1, 1'b0);

        // Last legal IM word then one past the end
        npc_sel   = 2'd3;
        D_rs_data = 32'h6FFC;
        edge1();
        chk("top.F_PC", F_PC, 32'h6FFC);
        npc_sel = 2'd0;
        edge1();
        chk_d("top_word", 32'h7000, 32'hC0DE_6FFC, 32'h6FFC, 32'h7004, 1'b1, 1'b0);

        npc_sel   = 2'd3;
        D_rs_data = 32'hFFFF_FFFC;
        edge1();
        chk_d("past_end", 32'hFFFF_FFFC, 32'h0, 32'h7000, 32'h7008, 1'b0, 1'b1);

        // PC+4 and PC+8 wrap modulo 2^32
        npc_sel = 2'd0;
        edge1();
        chk_d("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h4, 1'b0, 1'b1);

        // Below IM_BASE is illegal
        edge1();
        chk_d("below", 32'h4, 32'h0, 32'h0, 32'h8, 1'b0, 1'b1);

        // Mid-stream reset with stall and a pending jump: reset wins
        npc_sel   = 2'd3;
        D_rs_data = 32'h3040;
        edge1();
        chk("pre_rst.F_PC", F_PC, 32'h3040);
        stall   = 1'b1;
        npc_sel = 2'd2;
        reset   = 1'b1;
        edge1();
        chk_d("mid_reset", 32'h3000, 32'h0, 32'h3000, 32'h3008, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
